id_decode_buffer: RTL and testbench

//  Registered, parametrised RV32I instruction decode stage with an output FIFO and ready/valid handshake.

---
 rtl/id_decode_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_decode_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_buffer.sv
// RV32I decode stage: combinational field/immediate decode feeding a DEPTH-entry record FIFO.
// Optional macro ID_IMM_GEN_EN builds the immediate generator; otherwise imm_o is tied to 0.
module id_decode_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [ILEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            rd_we_o,
  output logic            rs1_re_o,
  output logic            rs2_re_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtIll = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            rd_we;
    logic            rs1_re;
    logic            rs2_re;
    logic [2:0]      fmt;
    logic            illegal;
  } rec_t;

  // Decode
  logic [31:0] inst;
  logic        legal;
  logic        use_rd, use_rs1, use_rs2, use_f3, use_f7;
  logic [2:0]  fmt;
  rec_t        dec;

  assign inst = inst_i[31:0];

  always_comb begin
    legal   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    fmt     = FmtIll;
    case (inst[6:0])
      OpR: begin
        fmt     = FmtR;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        use_f7  = 1'b1;
        legal   = (inst[31:25] == 7'h00) || (inst[31:25] == 7'h20);
      end
      OpImm, OpLoad, OpJalr: begin
        fmt     = FmtI;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
      end
      OpStore, OpBranch: begin
        fmt     = (inst[6:0] == OpStore) ? FmtS : FmtB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
      end
      OpLui, OpAuipc: begin
        fmt    = FmtU;
        use_rd = 1'b1;
      end
      OpJal: begin
        fmt    = FmtJ;
        use_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (inst[1:0] != 2'b11) legal = 1'b0;

    // Illegal records keep only pc and opcode.
    if (!legal) begin
      fmt     = FmtIll;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_f3  = 1'b0;
      use_f7  = 1'b0;
    end

    dec         = '0;
    dec.pc      = pc_i;
    dec.opcode  = inst[6:0];
    dec.rd      = use_rd  ? inst[11:7]  : 5'd0;
    dec.rs1     = use_rs1 ? inst[19:15] : 5'd0;
    dec.rs2     = use_rs2 ? inst[24:20] : 5'd0;
    dec.funct3  = use_f3  ? inst[14:12] : 3'd0;
    dec.funct7  = use_f7  ? inst[31:25] : 7'd0;
    dec.rd_we   = use_rd && (inst[11:7] != 5'd0);
    dec.rs1_re  = use_rs1;
    dec.rs2_re  = use_rs2;
    dec.fmt     = fmt;
    dec.illegal = !legal;
  end

`ifdef ID_IMM_GEN_EN
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_dec;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FmtI:    imm32 = {{20{inst[31]}}, inst[31:20]};
      FmtS:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU:    imm32 = {inst[31:12], 12'b0};
      FmtJ:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_dec = XLEN'($signed(imm32));
  end
`endif

  // FIFO control
  rec_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, push_en, pop_en;

  assign out_valid_o = (count_q != '0);
  assign in_ready_o  = (count_q < CntW'(DEPTH)) || out_ready_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign push_en     = push && !flush_i;
  assign pop_en      = pop && !flush_i;
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= dec;
    end
  end

`ifdef ID_IMM_GEN_EN
  logic [XLEN-1:0] imm_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
      end
    end else if (push_en) begin
      imm_q[wr_ptr_q] <= imm_dec;
    end
  end

  assign imm_o = out_valid_o ? imm_q[rd_ptr_q] : '0;
`else
  assign imm_o = '0;
`endif

  // Stale entries stay in storage; mask them whenever the FIFO is empty.
  rec_t head;

  always_comb begin
    head = '0;
    if (out_valid_o) head = mem_q[rd_ptr_q];
    pc_o      = head.pc;
    opcode_o  = head.opcode;
    rd_o      = head.rd;
    rs1_o     = head.rs1;
    rs2_o     = head.rs2;
    funct3_o  = head.funct3;
    funct7_o  = head.funct7;
    rd_we_o   = head.rd_we;
    rs1_re_o  = head.rs1_re;
    rs2_re_o  = head.rs2_re;
    fmt_o     = head.fmt;
    illegal_o = head.illegal;
  end

endmodule

// File: tb/tb_id_decode_buffer.sv
// Scoreboard bench for id_decode_buffer: drivers queue hand-computed records, a monitor
// pops and compares on every output handshake.
module tb_id_decode_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, pc_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o, fmt_o;
  logic        rd_we_o, rs1_re_o, rs2_re_o, illegal_o;
  logic [1:0]  count_o;

  always #5 clk = ~clk;

  id_decode_buffer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .inst_i     (inst),
    .pc_i       (pc),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .pc_o       (pc_o),
    .opcode_o   (opcode_o),
    .rd_o       (rd_o),
    .rs1_o      (rs1_o),
    .rs2_o      (rs2_o),
    .funct3_o   (funct3_o),
    .funct7_o   (funct7_o),
    .rd_we_o    (rd_we_o),
    .rs1_re_o   (rs1_re_o),
    .rs2_re_o   (rs2_re_o),
    .fmt_o      (fmt_o),
    .imm_o      (imm_o),
    .illegal_o  (illegal_o),
    .count_o    (count_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rd_we;
    logic        rs1_re;
    logic        rs2_re;
    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic we, input logic r1, input logic r2,
                              input logic [2:0] fmt, input logic ill, input logic [31:0] imm);
    exp_t e;
    e.pc = p;      e.opcode = op;  e.rd = rd;      e.rs1 = rs1;    e.rs2 = rs2;
    e.funct3 = f3; e.funct7 = f7;  e.rd_we = we;   e.rs1_re = r1;  e.rs2_re = r2;
    e.fmt = fmt;   e.illegal = ill;
`ifdef ID_IMM_GEN_EN
    e.imm = imm;
`else
    e.imm = '0;
`endif
    return e;
  endfunction

  // Monitor: one comparison per consumed head record.
  always @(negedge clk) begin
    exp_t a, e;
    if (!rst && !flush && out_valid && out_ready) begin
      a.pc = pc_o;         a.opcode = opcode_o; a.rd = rd_o;         a.rs1 = rs1_o;
      a.rs2 = rs2_o;       a.funct3 = funct3_o; a.funct7 = funct7_o; a.rd_we = rd_we_o;
      a.rs1_re = rs1_re_o; a.rs2_re = rs2_re_o; a.fmt = fmt_o;       a.illegal = illegal_o;
      a.imm = imm_o;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_output", 128'(a), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check(a == e, $sformatf("record_pc_%0h", e.pc), 128'(a), 128'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1;
    inst     = i;
    pc       = p;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check(1'b0, $sformatf("accept_timeout_pc_%0h", p), 128'(in_ready), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    logic [127:0] data;
    @(negedge clk);
    data = {pc_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, rd_we_o, rs1_re_o,
            rs2_re_o, fmt_o, illegal_o, imm_o};
    check(out_valid == 1'b0, {name, "_out_valid"}, 128'(out_valid), 128'(0));
    check(count_o == 2'd0, {name, "_count"}, 128'(count_o), 128'(0));
    check(in_ready == 1'b1, {name, "_in_ready"}, 128'(in_ready), 128'(1));
    check(data == '0, {name, "_data_zero"}, data, 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e_add, e_sw, e_beq, e_ill0, e_sub, e_ill7, e_lui, e_jal, e_addi, e_c;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; out_ready = 1'b0;
    tick(2);
    check_idle("reset");
    rst = 1'b0;

    // Single records with the consumer always ready.
    out_ready = 1'b1;
    e_add  = mk(32'h100, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 1, 1, 1, 3'd0, 0, 32'h0);
    e_sw   = mk(32'h104, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 0, 1, 1, 3'd2, 0, 32'h8);
    e_beq  = mk(32'h108, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 0, 1, 1, 3'd3, 0, 32'hFFFFFFFC);
    e_ill0 = mk(32'h10C, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 0, 0, 0, 3'd7, 1, 32'h0);
    e_sub  = mk(32'h110, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h20, 0, 1, 1, 3'd0, 0, 32'h0);
    e_ill7 = mk(32'h114, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 0, 0, 0, 3'd7, 1, 32'h0);
    e_lui  = mk(32'h118, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 1, 0, 0, 3'd4, 0, 32'h12345000);
    e_jal  = mk(32'h11C, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1, 0, 0, 3'd5, 0, 32'h8);
    e_addi = mk(32'h120, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 1, 1, 0, 3'd1, 0, 32'hFFFFFFFF);

    send(32'h002081B3, 32'h100, e_add);
    tick(1);
    check_idle("after_add");

    send(32'h0020A423, 32'h104, e_sw);
    send(32'hFE000EE3, 32'h108, e_beq);
    send(32'h00000000, 32'h10C, e_ill0);
    send(32'h40000033, 32'h110, e_sub);
    send(32'h7E000033, 32'h114, e_ill7);
    send(32'h123452B7, 32'h118, e_lui);
    send(32'h008000EF, 32'h11C, e_jal);
    send(32'hFFF00293, 32'h120, e_addi);
    tick(1);
    check_idle("after_stream");

    // Backpressure: fill both entries, third waits, then push and pop together.
    out_ready = 1'b0;
    e_add.pc = 32'h200;
    e_addi.pc = 32'h204;
    e_c = e_sub;
    e_c.pc = 32'h208;
    send(32'h002081B3, 32'h200, e_add);
    send(32'hFFF00293, 32'h204, e_addi);
    in_valid = 1'b1; inst = 32'h40000033; pc = 32'h208;
    @(negedge clk);
    check(count_o == 2'd2, "full_count", 128'(count_o), 128'(2));
    check(in_ready == 1'b0, "full_in_ready", 128'(in_ready), 128'(0));
    check(out_valid == 1'b1, "full_out_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(e_c);
    @(negedge clk);
    check(in_ready == 1'b1, "pushpop_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check(count_o == 2'd2, "pushpop_count", 128'(count_o), 128'(2));
    tick(3);
    check_idle("after_wrap");

    // Flush with two buffered records and an instruction offered in the flush cycle.
    out_ready = 1'b0;
    e_lui.pc = 32'h300;
    e_add.pc = 32'h304;
    send(32'h123452B7, 32'h300, e_lui);
    send(32'h002081B3, 32'h304, e_add);
    flush = 1'b1; in_valid = 1'b1; inst = 32'hFFF00293; pc = 32'h308;
    @(negedge clk);
    check(count_o == 2'd2, "pre_flush_count", 128'(count_o), 128'(2));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check_idle("after_flush");
    out_ready = 1'b1;
    tick(3);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b1, "flush_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check_idle("after_empty_flush");

    // Reset mid-stream drops buffered records.
    out_ready = 1'b0;
    e_add.pc = 32'h400;
    e_addi.pc = 32'h404;
    send(32'h002081B3, 32'h400, e_add);
    send(32'hFFF00293, 32'h404, e_addi);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_idle("reset_mid");
    rst = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check_idle("post_reset");

    check(exp_q.size() == 0, "scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
